// File: rtl/cmplx_mat_mul_seq.sv
// rtl/cmplx_mat_mul_seq.sv - time-shared complex matrix multiplier C = A x B with streamed results
// Optional sticky saturation flag port ovf when CMPLX_MAT_MUL_OVF_FLAG_EN is defined.
module cmplx_mat_mul_seq #(
  parameter int DIM          = 4,
  parameter int INTEGER_SIZE = 6,
  parameter int FRACT_SIZE   = 12,
  parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [DIM*DIM*2*DATA_WIDTH-1:0]    a_flat,
  input  logic [DIM*DIM*2*DATA_WIDTH-1:0]    b_flat,
  output logic                               busy,
  output logic [DATA_WIDTH-1:0]              c_r,
  output logic [DATA_WIDTH-1:0]              c_i,
  output logic [$clog2(DIM)-1:0]             c_row,
  output logic [$clog2(DIM)-1:0]             c_col,
  output logic                               c_valid,
  input  logic                               c_ready,
  output logic                               done
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
  ,
  output logic                               ovf
`endif
);

  localparam int DW     = DATA_WIDTH;
  localparam int IW     = $clog2(DIM);
  localparam int FLAT_W = DIM * DIM * 2 * DW;
  localparam int PW     = 2 * DW;
  localparam int ACC_W  = 2 * DW + 1 + IW;

  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) <<< (FRACT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) <<< (DW - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = -(ACC_W'(1) <<< (DW - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT, FIN} state_t;

  state_t                   state;
  logic [FLAT_W-1:0]        a_reg, b_reg;
  logic [IW-1:0]            i_idx, j_idx, k_idx;
  logic signed [ACC_W-1:0]  acc_r, acc_i;

  logic signed [DW-1:0] a_re [DIM][DIM];
  logic signed [DW-1:0] a_im [DIM][DIM];
  logic signed [DW-1:0] b_re [DIM][DIM];
  logic signed [DW-1:0] b_im [DIM][DIM];

  for (genvar gi = 0; gi < DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < DIM; gj++) begin : g_col
      assign a_re[gi][gj] = a_reg[(2*(gi*DIM+gj))*DW +: DW];
      assign a_im[gi][gj] = a_reg[(2*(gi*DIM+gj)+1)*DW +: DW];
      assign b_re[gi][gj] = b_reg[(2*(gi*DIM+gj))*DW +: DW];
      assign b_im[gi][gj] = b_reg[(2*(gi*DIM+gj)+1)*DW +: DW];
    end
  end

  // Single complex MAC: A[i][k] * B[k][j]
  logic signed [DW-1:0]    ar, ai, br, bi;
  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W-1:0] acc_r_nxt, acc_i_nxt;

  assign ar = a_re[i_idx][k_idx];
  assign ai = a_im[i_idx][k_idx];
  assign br = b_re[k_idx][j_idx];
  assign bi = b_im[k_idx][j_idx];

  assign p_rr = PW'(ar) * PW'(br);
  assign p_ii = PW'(ai) * PW'(bi);
  assign p_ri = PW'(ar) * PW'(bi);
  assign p_ir = PW'(ai) * PW'(br);

  assign acc_r_nxt = acc_r + ACC_W'(p_rr) - ACC_W'(p_ii);
  assign acc_i_nxt = acc_i + ACC_W'(p_ri) + ACC_W'(p_ir);

  // Round half toward +inf, drop fraction bits, then clamp each part
  logic signed [ACC_W-1:0] sh_r, sh_i;

  assign sh_r = (acc_r + RND) >>> FRACT_SIZE;
  assign sh_i = (acc_i + RND) >>> FRACT_SIZE;

  assign c_r = (sh_r > MAXV) ? MAXV[DW-1:0] : (sh_r < MINV) ? MINV[DW-1:0] : sh_r[DW-1:0];
  assign c_i = (sh_i > MAXV) ? MAXV[DW-1:0] : (sh_i < MINV) ? MINV[DW-1:0] : sh_i[DW-1:0];

  assign c_row = i_idx;
  assign c_col = j_idx;

`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
  logic sat_any;
  assign sat_any = (sh_r > MAXV) || (sh_r < MINV) || (sh_i > MAXV) || (sh_i < MINV);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      k_idx   <= '0;
      acc_r   <= '0;
      acc_i   <= '0;
      busy    <= 1'b0;
      c_valid <= 1'b0;
      done    <= 1'b0;
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_flat;
            b_reg <= b_flat;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            acc_r <= '0;
            acc_i <= '0;
            busy  <= 1'b1;
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
            ovf   <= 1'b0;
`endif
            state <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_r_nxt;
          acc_i <= acc_i_nxt;
          if (k_idx == IW'(DIM - 1)) begin
            k_idx   <= '0;
            c_valid <= 1'b1;
            state   <= OUT;
          end else begin
            k_idx <= k_idx + IW'(1);
          end
        end
        OUT: begin
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
          ovf <= ovf | sat_any;
`endif
          if (c_ready) begin
            c_valid <= 1'b0;
            acc_r   <= '0;
            acc_i   <= '0;
            k_idx   <= '0;
            if (j_idx == IW'(DIM - 1)) begin
              j_idx <= '0;
              if (i_idx == IW'(DIM - 1)) begin
                i_idx <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= FIN;
              end else begin
                i_idx <= i_idx + IW'(1);
                state <= MAC;
              end
            end else begin
              j_idx <= j_idx + IW'(1);
              state <= MAC;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmplx_mat_mul_seq.sv
// tb/tb_cmplx_mat_mul_seq.sv - directed vector bench for cmplx_mat_mul_seq
module tb_cmplx_mat_mul_seq;

  localparam int DIM    = 4;
  localparam int ISZ    = 6;
  localparam int FSZ    = 12;
  localparam int DW     = ISZ + FSZ;
  localparam int IW     = $clog2(DIM);
  localparam int NE     = DIM * DIM;
  localparam int FLAT_W = NE * 2 * DW;

  logic              clk_tb = 1'b0;
  logic              rst_n, start, c_ready;
  logic [FLAT_W-1:0] a_flat, b_flat, a_v, b_v;
  logic              busy, c_valid, done;
  logic [DW-1:0]     c_r, c_i;
  logic [IW-1:0]     c_row, c_col;
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
  logic              ovf;
`endif

  always #5 clk_tb = ~clk_tb;

  cmplx_mat_mul_seq #(.DIM(DIM), .INTEGER_SIZE(ISZ), .FRACT_SIZE(FSZ), .DATA_WIDTH(DW)) dut (
    .clk(clk_tb), .rst_n(rst_n), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .busy(busy), .c_r(c_r), .c_i(c_i), .c_row(c_row), .c_col(c_col),
    .c_valid(c_valid), .c_ready(c_ready), .done(done)
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_r [NE];
  logic [DW-1:0] got_i [NE];
  logic [IW-1:0] got_row [NE];
  logic [IW-1:0] got_col [NE];
  int rise [NE];
  int acc_cyc [NE];
  int n_acc, n_rise, done_cnt, done_cyc, stall_bad;
  logic busy_at0, busy_at_done;

  typedef struct {
    logic [DW-1:0] ar, ai, br, bi, er, ei;
    logic          ovf;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_r(input int n);
    return DW'(n * 1237 - 9000);
  endfunction

  function automatic logic [DW-1:0] pat_i(input int n);
    return DW'(31000 - n * 2111);
  endfunction

  task automatic put_a(input int i, input int j, input logic [DW-1:0] re, input logic [DW-1:0] im);
    a_v[(2*(i*DIM+j))*DW +: DW]   = re;
    a_v[(2*(i*DIM+j)+1)*DW +: DW] = im;
  endtask

  task automatic put_b(input int i, input int j, input logic [DW-1:0] re, input logic [DW-1:0] im);
    b_v[(2*(i*DIM+j))*DW +: DW]   = re;
    b_v[(2*(i*DIM+j)+1)*DW +: DW] = im;
  endtask

  task automatic set_ident();
    a_v = '0;
    b_v = '0;
    for (int d = 0; d < DIM; d++) put_a(d, d, 18'h01000, 18'h0);
    for (int n = 0; n < NE; n++) put_b(n / DIM, n % DIM, pat_r(n), pat_i(n));
  endtask

  // One full operation; optional stall of element stall_at, optional start pulse at element poke_at
  task automatic run_op(input int stall_at, input int poke_at);
    int   stall_cnt;
    logic pv;
    logic [2*DW+2*IW-1:0] snap;
    n_acc = 0; n_rise = 0; done_cnt = 0; done_cyc = -1; stall_bad = 0;
    stall_cnt = 0; pv = 1'b0; snap = '0; busy_at_done = 1'b1;
    for (int n = 0; n < NE; n++) begin
      got_r[n] = '0; got_i[n] = '0; got_row[n] = '0; got_col[n] = '0;
      rise[n] = -100; acc_cyc[n] = -100;
    end
    @(negedge clk_tb);
    a_flat = a_v; b_flat = b_v; start = 1'b1; c_ready = 1'b1;
    @(negedge clk_tb);
    start = 1'b0; a_flat = ~a_v; b_flat = ~b_v;
    busy_at0 = busy;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      start = 1'b0;
      if (c_valid && !pv) begin
        if (n_rise < NE) rise[n_rise] = cyc;
        if (n_rise == stall_at) begin
          stall_cnt = 6;
          snap = {c_r, c_i, c_row, c_col};
        end
        if (n_rise == poke_at) start = 1'b1;
        n_rise++;
      end
      if (stall_cnt > 0) begin
        if (stall_cnt < 6 && (({c_r, c_i, c_row, c_col} !== snap) || !c_valid)) stall_bad++;
        c_ready = (stall_cnt == 1);
        stall_cnt--;
      end
      if (c_valid && c_ready && n_acc < NE) begin
        got_r[n_acc] = c_r; got_i[n_acc] = c_i;
        got_row[n_acc] = c_row; got_col[n_acc] = c_col;
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      pv = c_valid;
      if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      @(negedge clk_tb);
    end
    start = 1'b0;
  endtask

  task automatic check_ident(input string tag);
    chk({tag, "_count"}, 64'(n_acc), 64'(NE));
    for (int n = 0; n < NE; n++)
      chk($sformatf("%s_elem%0d", tag, n),
          64'({got_r[n], got_i[n], got_row[n], got_col[n]}),
          64'({pat_r(n), pat_i(n), IW'(n / DIM), IW'(n % DIM)}));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin : main
    int z, pbad, dseen, nv;
    vt[0] = '{18'h01000, 18'h02000, 18'h02000, 18'h01000, 18'h00000, 18'h05000, 1'b0};
    vt[1] = '{18'h00001, 18'h00000, 18'h00800, 18'h00000, 18'h00001, 18'h00000, 1'b0};
    vt[2] = '{18'h1F000, 18'h00000, 18'h1F000, 18'h00000, 18'h1FFFF, 18'h00000, 1'b1};
    vt[3] = '{18'h1F000, 18'h00000, 18'h21000, 18'h00000, 18'h20000, 18'h00000, 1'b1};
    vt[4] = '{18'h00001, 18'h00000, 18'h007FF, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    vt[5] = '{18'h3FFFF, 18'h00000, 18'h00800, 18'h00000, 18'h00000, 18'h00000, 1'b0};
    vt[6] = '{18'h00000, 18'h01000, 18'h00000, 18'h01000, 18'h3F000, 18'h00000, 1'b0};

    rst_n = 1'b0; start = 1'b0; c_ready = 1'b1; a_flat = '0; b_flat = '0; a_v = '0; b_v = '0;
    repeat (2) @(negedge clk_tb);
    chk("rst_valid", 64'(c_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_data", 64'({c_r, c_i, c_row, c_col}), 64'(0));
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
    chk("rst_ovf", 64'(ovf), 64'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk_tb);
    chk("idle_valid", 64'(c_valid), 64'(0));

    set_ident();
    run_op(-1, -1);
    check_ident("id");
    pbad = 0;
    for (int n = 0; n + 1 < NE; n++) if (rise[n+1] - rise[n] != DIM + 1) pbad++;
    chk("id_first_latency", 64'(rise[0] + 1), 64'(DIM + 1));
    chk("id_period_bad", 64'(pbad), 64'(0));
    chk("id_done_cycle", 64'(done_cyc + 1), 64'(NE * (DIM + 1) + 1));
    chk("id_done_count", 64'(done_cnt), 64'(1));
    chk("id_busy_start", 64'(busy_at0), 64'(1));
    chk("id_busy_at_done", 64'(busy_at_done), 64'(0));

    for (int v = 0; v < 7; v++) begin
      a_v = '0; b_v = '0;
      put_a(0, 0, vt[v].ar, vt[v].ai);
      put_b(0, 0, vt[v].br, vt[v].bi);
      run_op(-1, -1);
      chk($sformatf("vec%0d_r", v), 64'(got_r[0]), 64'(vt[v].er));
      chk($sformatf("vec%0d_i", v), 64'(got_i[0]), 64'(vt[v].ei));
      z = 0;
      for (int n = 1; n < NE; n++) if (n >= n_acc || got_r[n] != 0 || got_i[n] != 0) z++;
      chk($sformatf("vec%0d_zero_elems", v), 64'(z), 64'(0));
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
      chk($sformatf("vec%0d_ovf", v), 64'(ovf), 64'(vt[v].ovf));
`endif
    end

    set_ident();
    run_op(6, -1);
    chk("bp_hold_bad", 64'(stall_bad), 64'(0));
    chk("bp_next_gap", 64'(rise[7] - acc_cyc[6]), 64'(DIM + 1));
    check_ident("bp");

    set_ident();
    run_op(-1, 8);
    check_ident("poke");
    chk("poke_done_count", 64'(done_cnt), 64'(1));

    // Reset during MAC of element (0,3)
    set_ident();
    @(negedge clk_tb);
    a_flat = a_v; b_flat = b_v; start = 1'b1; c_ready = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    nv = 0; dseen = 0;
    for (int t = 0; t < 200 && nv < 3; t++) begin
      @(negedge clk_tb);
      if (c_valid) nv++;
      if (done) dseen++;
    end
    chk("mr_reached_elem", 64'(nv), 64'(3));
    @(posedge clk_tb);
    #1;
    chk("mr_busy_before", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(c_valid), 64'(0));
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_done", 64'(done), 64'(0));
`ifdef CMPLX_MAT_MUL_OVF_FLAG_EN
    chk("mr_ovf", 64'(ovf), 64'(0));
`endif
    repeat (2) @(negedge clk_tb);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk_tb);
      if (done || c_valid) dseen++;
    end
    chk("mr_no_done", 64'(dseen), 64'(0));
    run_op(-1, -1);
    check_ident("post_rst");
    chk("post_rst_done_count", 64'(done_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmplx_mat_mul_seq.md
Name: cmplx_mat_mul_seq

Overview:
Parametrised successor to the fixed 4x4 complex matrix-multiply controller. Computes C = A x B for DIM x DIM complex fixed-point matrices in signed Q(INTEGER_SIZE.FRACT_SIZE) format, using one time-shared complex MAC. Operands are latched from flat packed buses on start. Results stream out one element per handshake (valid/ready), row-major, so the downstream consumer can apply backpressure.

Parameters:
DIM, 4, matrix dimension (2..16)
INTEGER_SIZE, 6, integer bits including sign
FRACT_SIZE, 12, fractional bits
DATA_WIDTH, INTEGER_SIZE+FRACT_SIZE, element component width (real or imag)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a multiply; sampled only in IDLE
a_flat  in  DIM*DIM*2*DATA_WIDTH  matrix A, packed (see Behaviour)
b_flat  in  DIM*DIM*2*DATA_WIDTH  matrix B, packed (see Behaviour)
busy  out  1  high from the cycle after start is accepted until done
c_r  out  DATA_WIDTH  result element, real part
c_i  out  DATA_WIDTH  result element, imaginary part
c_row  out  $clog2(DIM)  row index of the presented element
c_col  out  $clog2(DIM)  column index of the presented element
c_valid  out  1  c_* outputs valid
c_ready  in  1  consumer accepts the element when c_valid && c_ready
done  out  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). Every output and all state clear to 0; FSM returns to IDLE. Reset mid-operation abandons the current operation with no done pulse.
- Packing: element (i,j) real part = flat[(2*(i*DIM+j))*DATA_WIDTH +: DATA_WIDTH]; imaginary part = the next DATA_WIDTH bits.
- FSM states: IDLE, MAC, OUT, FIN.
  - IDLE: when start=1, latch a_flat and b_flat into internal registers, set i=j=k=0, clear the accumulators, set busy=1, go to MAC. Inputs may change after the start cycle.
  - MAC: one k per cycle, acc += A[i][k]*B[k][j]. After k=DIM-1, go to OUT.
  - OUT: c_valid=1 with c_r, c_i, c_row=i, c_col=j. All four hold stable while c_ready=0.
    - On handshake: advance j; when j wraps, advance i and reset j to 0. Clear the accumulators and k, then go to MAC.
    - On handshake for the last element (i=j=DIM-1): go to FIN instead.
  - FIN: done=1 and busy=0 for one cycle, then go to IDLE.
- start is ignored outside IDLE. Holding start high continuously restarts an operation the cycle after FIN.
- Latency: the first c_valid rises DIM+1 cycles after the start edge. With c_ready tied high, each following element appears every DIM+1 cycles. Total start-to-done is DIM*DIM*(DIM+1)+1 cycles.
- Arithmetic:
  - Products are full 2*DATA_WIDTH signed.
  - Real term = ar*br - ai*bi; imaginary term = ar*bi + ai*br.
  - Accumulator width is 2*DATA_WIDTH+1+$clog2(DIM), which cannot overflow internally.
- Output conversion:
  - Add 2^(FRACT_SIZE-1) to round half up toward +inf.
  - Arithmetic shift right by FRACT_SIZE.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], applied to real and imaginary parts independently.

Optional Feature:
CMPLX_MAT_MUL_OVF_FLAG_EN
- Defined: adds output port ovf (1 bit). ovf is sticky: it sets when any output component saturates and clears when start is accepted and on reset.
- Undefined: the ovf port is absent. Saturation behaviour is unchanged.

Test Plan:
- Identity: A = I (real diagonal 0x01000, all other components 0), B = arbitrary packed pattern, c_ready=1 -> 16 elements stream in row-major order, C == B bit-exact, c_row/c_col count 0..3, done pulses once at cycle 81 after start.
- Complex product: A11 = 1+2j (0x01000, 0x02000), B11 = 2+1j, all other components 0 -> element (0,0) is c_r=0, c_i=0x05000; all other elements are 0.
- Round/saturate:
  - A11 = 0x00001 (2^-12), B11 = 0x00800 (0.5) -> c_r(0,0)=0x00001 (rounded up).
  - A11 = B11 = 31.0 (0x1F000) -> c_r(0,0)=0x1FFFF; ovf=1 when the macro is defined.
  - Negative case: A11 = 31.0, B11 = -31.0 (0x21000) -> c_r(0,0)=0x20000.
- Backpressure: drop c_ready for 5 cycles while element (1,2) is presented -> c_valid stays 1, and c_r, c_i, c_row, c_col stay constant; the next element follows DIM+1 cycles after the handshake.
- Start while busy: pulse start at element (2,0) with different A/B -> ignored; results match the original operands and only one done pulse occurs.
- Reset mid-operation: assert rst_n=0 asynchronously during MAC of element (0,3) -> c_valid, busy, done and (when compiled in) ovf go to 0 immediately with no done pulse; a new start then completes correctly.
